// File: rtl/nand_gate_in_pipe_pkg.sv
// -----------------------------------------------------------------------------
// nand_gate_in_pipe_pkg
//   Shared definitions for the buffered NAND front-end stage:
//   - default parameter values for width, FIFO depth and counter width
//   - occupancy state encoding (EMPTY / PARTIAL / FULL)
//   - nand_f(): the bitwise NAND used by the datapath
// -----------------------------------------------------------------------------
package nand_gate_in_pipe_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = 16;

   // Occupancy of the result FIFO. Always derived from the level, never
   // from pointer comparison.
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_e;

   // Bitwise NAND at the widest supported operand width; callers narrow
   // the result back to their own width.
   function automatic logic [63:0] nand_f(input logic [63:0] a, input logic [63:0] b);
      return ~(a & b);
   endfunction

endpackage

// File: rtl/nand_gate_in_pipe_fifo.sv
// -----------------------------------------------------------------------------
// nand_gate_in_pipe_fifo
//   DEPTH-entry show-ahead result FIFO with an explicit occupancy state
//   machine. Full/empty come from the level, so pointers simply wrap.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (pointers, level, state)
//   push       write request; ignored while FULL
//   pop        read request; ignored while EMPTY
//   wdata      entry written on an accepted push
//   rdata      entry at the read pointer (show-ahead, combinational)
//   level      occupancy 0..DEPTH
//   occ_state  registered occupancy state
// -----------------------------------------------------------------------------
module nand_gate_in_pipe_fifo
   import nand_gate_in_pipe_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [LVL_W-1:0] level,
   output occ_state_e       occ_state
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_next_s;
   occ_state_e       occ_state_r;
   occ_state_e       occ_next_s;
   logic             wr_en_s;
   logic             rd_en_s;

   // Requests are qualified against our own state so a misbehaving caller
   // can never overrun or underrun the storage.
   assign wr_en_s = push & (occ_state_r != OCC_FULL);
   assign rd_en_s = pop  & (occ_state_r != OCC_EMPTY);

   // Next occupancy: push-only increments, pop-only decrements, both or neither hold.
   always_comb begin
      level_next_s = level_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   level_next_s = level_r + LVL_W'(1);
         2'b01:   level_next_s = level_r - LVL_W'(1);
         default: level_next_s = level_r;
      endcase
   end

   // Next occupancy state, decoded from the next level so state and level
   // never disagree after an edge.
   always_comb begin
      occ_next_s = occ_state_r;
      if (level_next_s == LVL_W'(0)) begin
         occ_next_s = OCC_EMPTY;
      end else if (level_next_s == LVL_W'(DEPTH)) begin
         occ_next_s = OCC_FULL;
      end else begin
         occ_next_s = OCC_PARTIAL;
      end
   end

   // Control state: pointers, level and occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= {LVL_W{1'b0}};
         occ_state_r <= OCC_EMPTY;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         level_r     <= level_next_s;
         occ_state_r <= occ_next_s;
      end
   end

   // Storage array; deliberately not reset, stale entries are unreachable
   // once the level is cleared.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata     = mem_r[rd_ptr_r];
   assign level     = level_r;
   assign occ_state = occ_state_r;

endmodule

// File: rtl/nand_gate_in_pipe.sv
// -----------------------------------------------------------------------------
// nand_gate_in_pipe
//   Buffered NAND front-end stage. Operand pairs accepted on the input
//   handshake are reduced to y = ~(a & b) at acceptance and queued; results
//   leave through the output handshake in order.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   stage can accept (not full)
//   in_a/in_b  operands
//   out_valid  result available (not empty)
//   out_ready  downstream accepts the result
//   out_y      head result; zero while empty
//   level      occupancy 0..DEPTH
//   txn_count  number of results popped, wraps silently
// -----------------------------------------------------------------------------
module nand_gate_in_pipe
   import nand_gate_in_pipe_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int LVL_W = $clog2(DEPTH) + 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [LVL_W-1:0] level,
   output logic [CNT_W-1:0] txn_count
);

   occ_state_e       occ_state_s;
   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] nand_s;
   logic [WIDTH-1:0] head_s;
   logic [CNT_W-1:0] txn_count_r;

   // Handshake outputs come straight from the registered occupancy state;
   // in_ready deliberately ignores out_ready (no pass-through when full).
   assign in_ready  = (occ_state_s != OCC_FULL);
   assign out_valid = (occ_state_s != OCC_EMPTY);
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;

   assign nand_s = WIDTH'(nand_f(64'(in_a), 64'(in_b)));

   nand_gate_in_pipe_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .pop       (pop_s),
      .wdata     (nand_s),
      .rdata     (head_s),
      .level     (level),
      .occ_state (occ_state_s)
   );

   // Head result is masked to zero while empty so stale storage never leaks.
   always_comb begin
      out_y = {WIDTH{1'b0}};
      if (out_valid) begin
         out_y = head_s;
      end else begin
         out_y = {WIDTH{1'b0}};
      end
   end

   // Completed-transaction counter, one step per accepted pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_count_r <= {CNT_W{1'b0}};
      end else if (pop_s) begin
         txn_count_r <= txn_count_r + CNT_W'(1);
      end
   end

   assign txn_count = txn_count_r;

endmodule

// File: tb/tb_nand_gate_in_pipe.sv
// -----------------------------------------------------------------------------
// tb_nand_gate_in_pipe
//   Directed bench for nand_gate_in_pipe (WIDTH=4, DEPTH=4, CNT_W=16).
//   A queue-based model tracks the expected results; a compare process
//   checks every output after each edge and after each reset assertion.
//   Hand-computed literals pin the model at key points.
// -----------------------------------------------------------------------------
module tb_nand_gate_in_pipe;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = 4'h0;
   logic [W-1:0]  in_b = 4'h0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_y;
   logic [2:0]    level;
   logic [CW-1:0] txn_count;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   logic [W-1:0]  mq[$];
   logic [CW-1:0] mcnt = 16'd0;

   nand_gate_in_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .level     (level),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   // Reference model and per-cycle compare.
   initial begin
      bit push, pop;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            mcnt = 16'd0;
         end else begin
            push = in_valid && (mq.size() < D);
            pop  = out_ready && (mq.size() > 0);
            if (pop) begin
               void'(mq.pop_front());
               mcnt = mcnt + 16'd1;
            end
            if (push) mq.push_back(~(in_a & in_b));
         end
         #1;
         if (chk_en) begin
            chk("m_in_ready",  32'(in_ready),  32'(mq.size() < D));
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("m_out_y",     32'(out_y),     (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("m_level",     32'(level),     32'(mq.size()));
            chk("m_txn_count", 32'(txn_count), 32'(mcnt));
         end
      end
   end

   task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] fill_exp [4];
      logic [W-1:0] full_exp [4];
      fill_exp = '{4'h0, 4'hF, 4'hF, 4'hF};
      full_exp = '{4'hD, 4'hC, 4'hB, 4'hC};

      chk_en = 1'b1;
      #1 rst = 1'b1;
      // Reset held 3 cycles with in_valid asserted: nothing captured.
      in_valid = 1'b1; in_a = 4'hF; in_b = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_in_ready",  32'(in_ready),  32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_y",     32'(out_y),     32'd0);
         chk("rst_level",     32'(level),     32'd0);
         chk("rst_txn",       32'(txn_count), 32'd0);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle_level", 32'(level), 32'd0);

      // Single transaction: ~(C & A) = 7.
      out_ready = 1'b0;
      push_pair(4'hC, 4'hA);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_y",     32'(out_y),     32'h7);
      chk("single_level", 32'(level),     32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("single_pop_valid", 32'(out_valid), 32'd0);
      chk("single_pop_txn",   32'(txn_count), 32'd1);

      // Fill to full with bit-replicated (1,1),(0,1),(1,0),(0,0).
      push_pair(4'hF, 4'hF);
      push_pair(4'h0, 4'hF);
      push_pair(4'hF, 4'h0);
      push_pair(4'h0, 4'h0);
      chk("full_level",    32'(level),    32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      push_pair(4'h5, 4'hF);   // ignored while full
      chk("full_ignore_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_y", 32'(out_y), 32'(fill_exp[i]));
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_txn",   32'(txn_count), 32'd5);

      // Full with simultaneous in_valid and out_ready: pop only.
      for (int i = 1; i <= 4; i++) push_pair(W'(i), 4'hF);
      in_valid = 1'b1; in_a = 4'h3; in_b = 4'hF;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("fullpp_level",    32'(level),    32'd3);
      chk("fullpp_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("fullpp_accept_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fullpp_y", 32'(out_y), 32'(full_exp[i]));
         @(negedge clk);
      end
      chk("fullpp_txn", 32'(txn_count), 32'd10);

      // Streaming across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a = W'($urandom_range(0, 15));
         in_b = W'($urandom_range(0, 15));
         @(negedge clk);
         chk("stream_level_le1", 32'(level <= 3'd1), 32'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      chk("stream_txn",   32'(txn_count), 32'd20);
      chk("stream_empty", 32'(out_valid), 32'd0);

      // Reset mid-operation at level 3, asserted between edges.
      push_pair(4'h1, 4'h1);
      push_pair(4'h2, 4'h2);
      push_pair(4'h4, 4'h4);
      chk("pre_rst_level", 32'(level), 32'd3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_level", 32'(level),     32'd0);
      chk("mid_rst_txn",   32'(txn_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push_pair(4'h6, 4'h3);
      chk("post_rst_y",     32'(out_y), 32'hD);
      chk("post_rst_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_rst_empty", 32'(out_valid), 32'd0);
      chk("post_rst_txn",   32'(txn_count), 32'd1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/nand_gate_in_pipe.md
Name: nand_gate_in_pipe

Overview:
- Buffered RTL front-end stage fed by the nand_gate_in interface. It accepts (a, b) operand transactions over a valid/ready handshake and computes y = ~(a & b) bitwise at acceptance.
- Results are queued in a DEPTH-entry FIFO and presented to the nand_gate_out side over a second valid/ready handshake.
- Maintains occupancy and a completed-transaction counter for scoreboard cross-checks.

Parameters:
- WIDTH, 1, operand/result bit width (1..64).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  stage can accept; equals !full.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- out_valid  out  1  result available; equals !empty.
- out_ready  in  1  downstream accepts the result.
- out_y  out  WIDTH  head-of-FIFO NAND result; forced to 0 when empty.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- txn_count  out  CNT_W  number of results popped; wraps modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous on rst rising, held while rst=1. Clears wr_ptr, rd_ptr, level, txn_count. FIFO storage is not reset.
- Outputs during and after reset: in_ready=1, out_valid=0, out_y=0, level=0, txn_count=0.
- Push: in_valid & in_ready at a rising edge. mem[wr_ptr] <= ~(in_a & in_b); wr_ptr advances modulo DEPTH.
- Pop: out_valid & out_ready at a rising edge. rd_ptr advances modulo DEPTH; txn_count increments.
- Show-ahead read: out_y = mem[rd_ptr] combinationally while out_valid=1.
- Latency: a push into an empty FIFO makes out_valid=1 with that result in the next cycle. There is no same-cycle bypass from in_* to out_*.
- Occupancy state machine, derived from level:
  - EMPTY (level=0): out_valid=0, in_ready=1.
  - PARTIAL (0<level<DEPTH): both handshake outputs high.
  - FULL (level=DEPTH): in_ready=0, out_valid=1.
  - Transitions move by at most one step per cycle: push only increments level, pop only decrements, push+pop leaves it unchanged.
- Simultaneous push and pop:
  - In PARTIAL: both occur, level unchanged, pointers both advance.
  - In EMPTY: only the push can occur, because out_valid=0.
  - In FULL: only the pop occurs, because in_ready=0 (in_ready is not a function of out_ready). level drops to DEPTH-1 and in_ready rises the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided from level, not from pointer equality.
- in_valid while in_ready=0 is ignored; no error, the data is not captured. Upstream must hold the pair until accepted.
- out_y is stable while out_valid=1 and out_ready=0.
- txn_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: all queued results are discarded. The stage returns to EMPTY within the same cycle rst asserts.
- X handling: no state update when in_valid=0, regardless of in_a/in_b values.

Decomposition:
- Shared package nand_gate_in_pipe_pkg holds:
  - default WIDTH/DEPTH/CNT_W localparams.
  - typedef for the occupancy state enum {EMPTY, PARTIAL, FULL}, used for debug/assertions.
  - function nand_f(a, b) returning ~(a & b), used by RTL and the reference model.
- One sub-module: nand_gate_in_pipe_fifo. It holds the storage array, pointers and level. The top-level keeps the NAND datapath, handshake glue and txn_count.

Test Plan:
- Reset and idle: assert rst for 3 cycles with in_valid=1 → in_ready=1, out_valid=0, out_y=0, level=0, txn_count=0 throughout; nothing captured.
- Single transaction, WIDTH=4: push a=4'hC, b=4'hA with out_ready=0 → next cycle out_valid=1, out_y=4'h7, level=1. Then out_ready=1 for one cycle → out_valid=0, txn_count=1.
- Fill to full, DEPTH=4: push (1,1), (0,1), (1,0), (0,0) at WIDTH=1 with out_ready=0 → level=4, in_ready=0; a fifth in_valid is ignored. Then drain → results 0, 1, 1, 1 in order, txn_count=4.
- Full with simultaneous in_valid and out_ready → one pop only, level=3. In the next cycle in_ready=1 and the held pair is accepted.
- Streaming wrap: 10 back-to-back random pairs with in_valid=1 and out_ready=1 → level stays ≤1 after the first push. Output sequence matches nand_f in order across pointer wrap; txn_count=10.
- Reset mid-operation at level=3: pulse rst asynchronously between edges → out_valid drops immediately, level=0, txn_count=0. The next push yields only the new result.
